// File: rtl/fmul_issue_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fmul_issue_unit                                                 |
// | Purpose : request FIFO + sequencer holding operands on a multicycle fmul  |
// |           path, returning tagged results over a valid/ready handshake.    |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module fmul_issue_unit #(
  parameter int TAG_W      = 5,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      fm_x1,
  output logic [31:0]      fm_x2,
  input  logic [31:0]      fm_y,
  input  logic             fm_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag,
  input  logic             flush,
  input  logic             flag_clr,
  output logic             ovf_sticky,
  output logic             busy
);

  localparam int              c_ptr_w  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_ptr_w:0] c_depth = (c_ptr_w+1)'(FIFO_DEPTH);
  localparam logic [3:0]      c_lat_m1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_cnt;
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_ptr_w:0]   r_count;
  logic [31:0]        r_mem_x1  [FIFO_DEPTH];
  logic [31:0]        r_mem_x2  [FIFO_DEPTH];
  logic [TAG_W-1:0]   r_mem_tag [FIFO_DEPTH];
  logic [31:0]        r_fm_x1;
  logic [31:0]        r_fm_x2;
  logic [TAG_W-1:0]   r_tag;
  logic [31:0]        r_out_y;
  logic               r_out_ovf;
  logic [TAG_W-1:0]   r_out_tag;
  logic               r_out_valid;
  logic               r_ovf_sticky;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_capture;
  logic w_release;

  // Ready depends only on the registered count, never on a same-cycle pop.
  assign w_full   = (r_count == c_depth);
  assign w_empty  = (r_count == '0);
  assign w_push   = in_valid && !w_full && !flush;
  assign in_ready = !w_full;

  assign fm_x1      = r_fm_x1;
  assign fm_x2      = r_fm_x2;
  assign out_y      = r_out_y;
  assign out_ovf    = r_out_ovf;
  assign out_tag    = r_out_tag;
  assign out_valid  = r_out_valid;
  assign ovf_sticky = r_ovf_sticky;
  assign busy       = (r_state != S_IDLE) || !w_empty;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt == 4'd0) begin
            w_capture   = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            w_release = 1'b1;
            if (!w_empty) begin
              w_pop       = 1'b1;
              w_state_nxt = S_EXEC;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Storage array needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_x1[r_wptr]  <= in_x1;
      r_mem_x2[r_wptr]  <= in_x2;
      r_mem_tag[r_wptr] <= in_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_cnt        <= 4'd0;
      r_fm_x1      <= 32'd0;
      r_fm_x2      <= 32'd0;
      r_tag        <= '0;
      r_out_y      <= 32'd0;
      r_out_ovf    <= 1'b0;
      r_out_tag    <= '0;
      r_out_valid  <= 1'b0;
      r_ovf_sticky <= 1'b0;
    end else if (flush) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // Operands only move on a pop, keeping the fmul inputs stable through EXEC.
      if (w_pop) begin
        r_fm_x1 <= r_mem_x1[r_rptr];
        r_fm_x2 <= r_mem_x2[r_rptr];
        r_tag   <= r_mem_tag[r_rptr];
        r_cnt   <= c_lat_m1;
      end else if (r_state == S_EXEC && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_capture) begin
        r_out_y     <= fm_y;
        r_out_ovf   <= fm_ovf;
        r_out_tag   <= r_tag;
        r_out_valid <= 1'b1;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end

      if (w_capture && fm_ovf) begin
        r_ovf_sticky <= 1'b1;
      end else if (flag_clr) begin
        r_ovf_sticky <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
